// File: rtl/mmio_arb_pkg.sv
// Shared types and constants for the two-master MMIO bus arbiter.
package mmio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mmio_req_t;

    localparam logic [31:0] MMIO_BASE         = 32'h8000_0000;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/mmio_arb_rr_pick.sv
// Two-way combinational request picker: round-robin against the last winner,
// or fixed priority to requester 0 when rr_en is low.
module mmio_arb_rr_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       rr_en,
    output logic       gnt_valid,
    output logic       gnt_id
);
    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        if (req == 2'b11) begin
            gnt_id = rr_en ? ~last_grant : 1'b0;
        end else if (req[1]) begin
            gnt_id = 1'b1;
        end
    end
endmodule

// File: rtl/mmio_bus_arbiter.sv
// Shares one MMIO slave port between the CPU memory controller (m0) and the
// debug/loader engine (m1); one transaction at a time, with an optional timeout.
module mmio_bus_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int          RR_EN     = 1,
    parameter int          TIMEOUT   = 256,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,
    input  logic        m1_valid,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,
    output logic        s_valid,
    output logic        s_write,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    output logic        grant_id
);
    localparam int             CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0]  TMO_MAX  = '1;

    arb_state_e        state_q, state_d;
    mmio_req_t         req_q, req_d;
    logic              s_valid_q, s_valid_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [CW-1:0]     tmo_q, tmo_d;
    logic [1:0][31:0]  rdata_q, rdata_d;
    logic [1:0]        ready_q, ready_d;
    logic [1:0]        err_q, err_d;

    logic              gnt_valid, gnt_id;
    mmio_req_t         m0_req, m1_req;

    assign m0_req = '{write: m0_write, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    assign m1_req = '{write: m1_write, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

    mmio_arb_rr_pick u_pick (
        .req        ({m1_valid, m0_valid}),
        .last_grant (last_q),
        .rr_en      (RR_EN != 0),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        s_valid_d = s_valid_q;
        grant_d   = grant_q;
        last_d    = last_q;
        tmo_d     = tmo_q;
        rdata_d   = rdata_q;
        ready_d   = 2'b00;
        err_d     = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    req_d     = gnt_id ? m1_req : m0_req;
                    s_valid_d = 1'b1;
                    grant_d   = gnt_id;
                    last_d    = gnt_id;
                    tmo_d     = '0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
                // A late ack in the expiry cycle still completes the access normally.
                if (s_ready) begin
                    s_valid_d         = 1'b0;
                    rdata_d[grant_q]  = s_rdata;
                    ready_d[grant_q]  = 1'b1;
                    state_d           = ST_RESP;
                end else if (TIMEOUT != 0 && tmo_q == TMO_LAST) begin
                    s_valid_d         = 1'b0;
                    rdata_d[grant_q]  = ERR_RDATA;
                    ready_d[grant_q]  = 1'b1;
                    err_d[grant_q]    = 1'b1;
                    state_d           = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            s_valid_q <= 1'b0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            tmo_q     <= '0;
            rdata_q   <= '0;
            ready_q   <= 2'b00;
            err_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            s_valid_q <= s_valid_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            tmo_q     <= tmo_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    assign s_valid  = s_valid_q;
    assign s_write  = req_q.write;
    assign s_addr   = req_q.addr;
    assign s_wdata  = req_q.wdata;
    assign s_wstrb  = req_q.wstrb;
    assign grant_id = grant_q;
    assign m0_rdata = rdata_q[0];
    assign m1_rdata = rdata_q[1];
    assign m0_ready = ready_q[0];
    assign m1_ready = ready_q[1];
    assign m0_err   = err_q[0];
    assign m1_err   = err_q[1];
endmodule
